// File: rtl/autocorr_engine.sv
// Frame autocorrelation engine: windows a speech frame, accumulates r[0..ORDER]
// with Q31 saturating MACs, rescales on lag-0 overflow, then normalises and emits.
module autocorr_engine #(
    parameter int WIN_LEN = 240,
    parameter int ORDER   = 10,
    parameter int AW      = 8,
    parameter int RW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] xAddr,
    output logic          xRe,
    input  logic [15:0]   xData,
    input  logic [15:0]   wData,
    output logic [RW-1:0] rAddr,
    output logic [31:0]   rData,
    output logic          rWe,
    output logic [4:0]    normExp,
    output logic [3:0]    scaleCount,
    output logic          busy,
    output logic          done
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_N = CW'(WIN_LEN);
    localparam logic [CW-1:0] LAST_S = CW'(WIN_LEN - 1);
    localparam logic [RW-1:0] LAST_K = RW'(ORDER);

    typedef enum logic [2:0] {IDLE, LOAD, ACC, SCALE, NORM, WRITE, DONE} state_t;

    state_t state, state_nx;

    logic        [CW-1:0] cnt;
    logic        [RW-1:0] lag;
    logic signed [31:0]   acc;
    logic                 ovf;

    logic signed [15:0] ybuf  [WIN_LEN];
    logic signed [31:0] rfile [ORDER+1];

    logic        [AW-1:0] idx_a, idx_b, ld_idx;
    logic signed [31:0]   ya, yb, prod_raw, prod, mac_val;
    logic signed [32:0]   sum;
    logic                 prod_sat, sum_sat, mac_sat;

    function automatic logic signed [15:0] mult_r(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b) + 32'sd16384;
        // only 0x8000*0x8000 can push the rounded result past +32767
        if (p[31:30] == 2'b01)
            return 16'sh7FFF;
        return p[30:15];
    endfunction

    function automatic logic [4:0] norm_l(input logic [31:0] v);
        logic [31:0] m;
        logic        hit;
        logic [4:0]  n;
        m   = v[31] ? ~v : v;
        n   = '0;
        hit = 1'b0;
        if (v != '0) begin
            for (int unsigned i = 0; i < 31; i++) begin
                if (!hit && !m[30-i])
                    n = n + 1'b1;
                else
                    hit = 1'b1;
            end
        end
        return n;
    endfunction

    // L_mac datapath: one sample pair per ACC cycle
    always_comb begin
        idx_a    = (cnt < LAST_N) ? cnt[AW-1:0] : '0;
        idx_b    = idx_a - AW'(lag);
        ld_idx   = cnt[AW-1:0] - 1'b1;
        ya       = 32'(ybuf[idx_a]);
        yb       = 32'(ybuf[idx_b]);
        prod_raw = ya * yb;
        prod_sat = (prod_raw == 32'sh4000_0000);
        prod     = prod_sat ? 32'sh7FFF_FFFF : (prod_raw <<< 1);
        sum      = 33'(acc) + 33'(prod);
        sum_sat  = sum[32] ^ sum[31];
        mac_val  = sum_sat ? (sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : sum[31:0];
        mac_sat  = prod_sat | sum_sat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lag        <= '0;
            acc        <= '0;
            ovf        <= 1'b0;
            normExp    <= '0;
            scaleCount <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt        <= '0;
                        scaleCount <= '0;
                    end
                end
                LOAD: begin
                    if (cnt == LAST_N) begin
                        cnt <= '0;
                        lag <= '0;
                        acc <= 32'sd1;
                        ovf <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACC: begin
                    if (cnt != LAST_N) begin
                        acc <= mac_val;
                        cnt <= cnt + 1'b1;
                        if (lag == '0 && mac_sat)
                            ovf <= 1'b1;
                    end else if (lag == '0 && ovf) begin
                        cnt <= '0;
                    end else if (lag != LAST_K) begin
                        lag <= lag + 1'b1;
                        cnt <= CW'(lag) + 1'b1;
                        acc <= '0;
                    end
                end
                SCALE: begin
                    if (cnt == LAST_S) begin
                        cnt <= '0;
                        lag <= '0;
                        acc <= 32'sd1;
                        ovf <= 1'b0;
                        if (scaleCount != '1)
                            scaleCount <= scaleCount + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                NORM: begin
                    normExp <= norm_l(rfile[0]);
                    lag     <= '0;
                end
                WRITE: begin
                    if (lag != LAST_K)
                        lag <= lag + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // sample buffer and result file are deliberately not reset
    always_ff @(posedge clk) begin
        if (state == LOAD && cnt != '0)
            ybuf[ld_idx] <= mult_r($signed(xData), $signed(wData));
        if (state == SCALE)
            ybuf[idx_a] <= ybuf[idx_a] >>> 2;
        if (state == ACC && cnt == LAST_N)
            rfile[lag] <= acc;
    end

    always_comb begin
        state_nx = state;
        xRe      = 1'b0;
        xAddr    = '0;
        rWe      = 1'b0;
        rAddr    = '0;
        rData    = '0;
        busy     = (state != IDLE);
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = LOAD;
            end
            LOAD: begin
                if (cnt != LAST_N) begin
                    xRe   = 1'b1;
                    xAddr = cnt[AW-1:0];
                end else begin
                    state_nx = ACC;
                end
            end
            ACC: begin
                if (cnt == LAST_N) begin
                    if (lag == '0 && ovf)
                        state_nx = SCALE;
                    else if (lag == LAST_K)
                        state_nx = NORM;
                end
            end
            SCALE: begin
                if (cnt == LAST_S)
                    state_nx = ACC;
            end
            NORM: state_nx = WRITE;
            WRITE: begin
                rWe   = 1'b1;
                rAddr = lag;
                rData = rfile[lag] << normExp;
                if (lag == LAST_K)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_autocorr_engine.sv
// Directed bench for autocorr_engine: default-size frames plus a WIN_LEN=8/ORDER=2 instance.
module tb_autocorr_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start_s;
    logic [7:0]  x_addr;
    logic        x_re, r_we, busy, done;
    logic [15:0] x_data = '0, w_data = '0;
    logic [3:0]  r_addr, scale_cnt;
    logic [31:0] r_data;
    logic [4:0]  norm_exp;

    logic [2:0]  xa_s;
    logic        xre_s, rwe_s, busy_s, done_s;
    logic [15:0] xd_s = '0, wd_s = '0;
    logic [1:0]  ra_s;
    logic [31:0] rd_s;
    logic [4:0]  ne_s;
    logic [3:0]  sc_s;

    autocorr_engine u_dut (
        .clk(clk), .reset(reset), .start(start),
        .xAddr(x_addr), .xRe(x_re), .xData(x_data), .wData(w_data),
        .rAddr(r_addr), .rData(r_data), .rWe(r_we),
        .normExp(norm_exp), .scaleCount(scale_cnt), .busy(busy), .done(done)
    );

    autocorr_engine #(.WIN_LEN(8), .ORDER(2), .AW(3), .RW(2)) u_small (
        .clk(clk), .reset(reset), .start(start_s),
        .xAddr(xa_s), .xRe(xre_s), .xData(xd_s), .wData(wd_s),
        .rAddr(ra_s), .rData(rd_s), .rWe(rwe_s),
        .normExp(ne_s), .scaleCount(sc_s), .busy(busy_s), .done(done_s)
    );

    logic [15:0] xmem [256];
    logic [15:0] wmem [256];
    logic [15:0] xmem_s [8];
    logic [15:0] wmem_s [8];

    always @(posedge clk) begin
        if (x_re) begin
            x_data <= xmem[x_addr];
            w_data <= wmem[x_addr];
        end
        if (xre_s) begin
            xd_s <= xmem_s[xa_s];
            wd_s <= wmem_s[xa_s];
        end
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] cap   [16];
    logic [31:0] cap_s [4];
    int we_cnt, done_cnt, addr_err, next_addr;
    int we_s, done_cnt_s, aerr_s, next_s;

    always @(negedge clk) begin
        if (reset) begin
            if (r_we) begin
                if (int'(r_addr) != next_addr) addr_err++;
                cap[r_addr] = r_data;
                we_cnt++;
                next_addr++;
            end
            if (done) done_cnt++;
            if (rwe_s) begin
                if (int'(ra_s) != next_s) aerr_s++;
                cap_s[ra_s] = rd_s;
                we_s++;
                next_s++;
            end
            if (done_s) done_cnt_s++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_main(input logic [15:0] xv, input logic [15:0] wv);
        for (int i = 0; i < 256; i++) begin
            xmem[i] = xv;
            wmem[i] = wv;
        end
    endtask

    task automatic fill_small(input logic [15:0] xv, input logic [15:0] wv);
        for (int i = 0; i < 8; i++) begin
            xmem_s[i] = xv;
            wmem_s[i] = wv;
        end
    endtask

    task automatic clear_main();
        for (int i = 0; i < 16; i++) cap[i] = 32'hDEAD_BEEF;
        we_cnt = 0; done_cnt = 0; addr_err = 0; next_addr = 0;
    endtask

    task automatic clear_small();
        for (int i = 0; i < 4; i++) cap_s[i] = 32'hDEAD_BEEF;
        we_s = 0; done_cnt_s = 0; aerr_s = 0; next_s = 0;
    endtask

    task automatic wait_done_main(input string tag, input int budget);
        int c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic wait_done_small(input string tag, input int budget);
        int c = 0;
        while (!done_s && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, 32'(done_s), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start_main();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start_small();
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_xAddr"}, 32'(x_addr), 32'd0);
        chk({tag, "_xRe"}, 32'(x_re), 32'd0);
        chk({tag, "_rAddr"}, 32'(r_addr), 32'd0);
        chk({tag, "_rData"}, r_data, 32'd0);
        chk({tag, "_rWe"}, 32'(r_we), 32'd0);
        chk({tag, "_normExp"}, 32'(norm_exp), 32'd0);
        chk({tag, "_scaleCount"}, 32'(scale_cnt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        reset   = 1'b0;
        start   = 1'b0;
        start_s = 1'b0;
        fill_main(16'h0000, 16'h7FFF);
        fill_small(16'h0000, 16'h7FFF);
        clear_main();
        clear_small();
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b1;
        @(negedge clk);

        // silent frame: only the +1 accumulator seed survives, normalised by 30
        clear_main();
        pulse_start_main();
        wait_done_main("A", 10000);
        @(negedge clk);
        chk("A_r0", cap[0], 32'h4000_0000);
        for (int k = 1; k <= 10; k++) chk($sformatf("A_r%0d", k), cap[k], 32'd0);
        chk("A_normExp", 32'(norm_exp), 32'd30);
        chk("A_scale", 32'(scale_cnt), 32'd0);
        chk("A_we", 32'(we_cnt), 32'd11);
        chk("A_donecnt", 32'(done_cnt), 32'd1);
        chk("A_order", 32'(addr_err), 32'd0);
        chk("A_idle", 32'(busy), 32'd0);

        // full-scale frame with start held high throughout: y=0x7FFE, two rescales to 0x07FF
        fill_main(16'h7FFF, 16'h7FFF);
        clear_main();
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("C_busy", 32'(busy), 32'd1);
        wait_done_main("C", 10000);
        @(negedge clk);
        chk("C_r0", cap[0], 32'h77E2_01E1);
        chk("C_r1", cap[1], 32'd239 * 32'd2 * 32'd2047 * 32'd2047);
        chk("C_r10", cap[10], 32'd230 * 32'd2 * 32'd2047 * 32'd2047);
        chk("C_normExp", 32'(norm_exp), 32'd0);
        chk("C_scale", 32'(scale_cnt), 32'd2);
        chk("C_we", 32'(we_cnt), 32'd11);
        chk("C_donecnt", 32'(done_cnt), 32'd1);
        chk("C_order", 32'(addr_err), 32'd0);
        @(posedge clk);
        #1;
        chk("C2_accepted", 32'(busy), 32'd1);
        chk("C2_scale_clr", 32'(scale_cnt), 32'd0);
        @(negedge clk);
        start = 1'b0;
        clear_main();

        // 1300 cycles in: third lag-0 pass, after two rescales
        repeat (1300) @(negedge clk);
        chk("C2_busy", 32'(busy), 32'd1);
        chk("C2_xRe", 32'(x_re), 32'd0);
        chk("C2_scale", 32'(scale_cnt), 32'd2);
        reset = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("midrst_we", 32'(we_cnt), 32'd0);
        chk("midrst_done", 32'(done_cnt), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

        // single impulse 0x4000: r0 = 1 + 2^29, one redundant sign bit
        fill_main(16'h0000, 16'h7FFF);
        xmem[0] = 16'h4000;
        clear_main();
        pulse_start_main();
        wait_done_main("B", 10000);
        @(negedge clk);
        chk("B_r0", cap[0], 32'h4000_0002);
        for (int k = 1; k <= 10; k++) chk($sformatf("B_r%0d", k), cap[k], 32'd0);
        chk("B_normExp", 32'(norm_exp), 32'd1);
        chk("B_scale", 32'(scale_cnt), 32'd0);
        chk("B_we", 32'(we_cnt), 32'd11);

        // small instance latency: edges from the accepting edge until done
        fill_small(16'h0000, 16'h7FFF);
        clear_small();
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        lat = 0;
        while (!done_s && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("S_latency", 32'(lat), 32'd37);
        @(negedge clk);
        @(negedge clk);
        chk("S_r0", cap_s[0], 32'h4000_0000);
        chk("S_r1", cap_s[1], 32'd0);
        chk("S_r2", cap_s[2], 32'd0);
        chk("S_we", 32'(we_s), 32'd3);
        chk("S_order", 32'(aerr_s), 32'd0);

        // x=w=0x7FFF: y=0x7FFE overflows lag 0 once, rescaled to 0x1FFF
        fill_small(16'h7FFF, 16'h7FFF);
        clear_small();
        pulse_start_small();
        wait_done_small("S2", 1000);
        chk("S2_r0", cap_s[0], 32'h7FF8_0022);
        chk("S2_r1", cap_s[1], 32'h6FF9_001C);
        chk("S2_r2", cap_s[2], 32'h5FFA_0018);
        chk("S2_normExp", 32'(ne_s), 32'd1);
        chk("S2_scale", 32'(sc_s), 32'd1);
        chk("S2_we", 32'(we_s), 32'd3);
        chk("S2_donecnt", 32'(done_cnt_s), 32'd1);
        chk("S2_order", 32'(aerr_s), 32'd0);

        // 0x8000*0x8000 windowing saturates to 0x7FFF, giving the same rescaled frame
        fill_small(16'h8000, 16'h8000);
        clear_small();
        pulse_start_small();
        wait_done_small("S3", 1000);
        chk("S3_r0", cap_s[0], 32'h7FF8_0022);
        chk("S3_r1", cap_s[1], 32'h6FF9_001C);
        chk("S3_r2", cap_s[2], 32'h5FFA_0018);
        chk("S3_scale", 32'(sc_s), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
